// File: rtl/divider.sv
// Sequential restoring unsigned divider: one quotient bit per clock, level-style
// ready flag. A zero divisor short-circuits to an all-ones quotient one cycle later.
module divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ready,
  output logic                  busy,
  output logic                  div_by_zero
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, stateNxt;
  logic [DIVIDEND_W-1:0] dvdShift;
  logic [DIVISOR_W-1:0]  dvsReg;
  logic [DIVISOR_W:0]    partRem;
  logic [CNT_W-1:0]      iterCnt;
  logic                  dbzPend;

  logic                  accept, lastIter, geq;
  logic [DIVISOR_W:0]    shifted, remNxt;
  logic [DIVIDEND_W-1:0] quoNxt;

  // dbzPend marks the single cycle between a zero-divisor start and its result
  assign accept   = start && !dbzPend && (state == IDLE || state == DONE);
  assign lastIter = (state == RUN) && (iterCnt == CNT_W'(DIVIDEND_W - 1));

  always_comb begin
    shifted = {partRem[DIVISOR_W-1:0], dvdShift[DIVIDEND_W-1]};
    geq     = shifted >= {1'b0, dvsReg};
    remNxt  = geq ? shifted - {1'b0, dvsReg} : shifted;
    quoNxt  = {dvdShift[DIVIDEND_W-2:0], geq};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE, DONE: if (accept) stateNxt = (divisor == '0) ? DONE : RUN;
      RUN:        if (lastIter) stateNxt = DONE;
      default:    stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvdShift    <= '0;
      dvsReg      <= '0;
      partRem     <= '0;
      iterCnt     <= '0;
      dbzPend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (dbzPend) begin
      dbzPend     <= 1'b0;
      quotient    <= '1;
      remainder   <= '0;
      div_by_zero <= 1'b1;
      ready       <= 1'b1;
    end else if (accept) begin
      dvdShift    <= dividend;
      dvsReg      <= divisor;
      partRem     <= '0;
      iterCnt     <= '0;
      dbzPend     <= (divisor == '0);
      busy        <= (divisor != '0);
      quotient    <= '0;
      remainder   <= '0;
      ready       <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (state == RUN) begin
      partRem  <= remNxt;
      dvdShift <= quoNxt;
      iterCnt  <= iterCnt + 1'b1;
      if (lastIter) begin
        quotient    <= quoNxt;
        remainder   <= remNxt[DIVISOR_W-1:0];
        ready       <= 1'b1;
        busy        <= 1'b0;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: expected results queued at start, checked on ready.
module tb_divider;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  logic                  clk = 1'b0;
  logic                  reset, start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  ready, busy, div_by_zero;

  divider #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .ready(ready), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DIVIDEND_W-1:0] q;
    logic [DIVISOR_W-1:0]  r;
    logic                  dbz;
    int                    lat;
  } exp_t;

  exp_t expQ[$];
  int   nTests = 0, nFail = 0;
  int   cyc = 0, e0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // never both high
  always @(negedge clk)
    if (busy && ready) begin
      nTests++; nFail++;
      $display("FAIL busyReady: busy=%0b ready=%0b required not both 1", busy, ready);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // pulse start across one rising edge (E0) and enqueue the model result
  task automatic startOp(input logic [DIVIDEND_W-1:0] a, input logic [DIVISOR_W-1:0] b);
    exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    e0 = cyc + 1;
    #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    if (b == 0) begin e.q = '1; e.r = '0; e.dbz = 1'b1; e.lat = 1; end
    else begin e.q = a / b; e.r = DIVISOR_W'(a % b); e.dbz = 1'b0; e.lat = DIVIDEND_W; end
    expQ.push_back(e);
    chk("readyDropAtE0", {31'b0, ready}, 0);
    chk("busyAtE0", {31'b0, busy}, {31'b0, b != 0});
  endtask

  task automatic waitDone(input string tag);
    exp_t e;
    int   n;
    e = expQ.pop_front();
    n = cyc - e0;
    while (!ready && n < 40) begin
      if (busy !== !e.dbz) chk({tag, ".busyRun"}, {31'b0, busy}, {31'b0, !e.dbz});
      @(posedge clk); #1;
      n = cyc - e0;
    end
    chk({tag, ".latency"}, n, e.lat);
    chk({tag, ".quotient"}, quotient, e.q);
    chk({tag, ".remainder"}, remainder, e.r);
    chk({tag, ".dbz"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
    @(posedge clk); #1;
    chk({tag, ".holdReady"}, {31'b0, ready}, 1);
    chk({tag, ".holdQuot"}, quotient, e.q);
  endtask

  task automatic runOp(input string tag, input logic [DIVIDEND_W-1:0] a,
                       input logic [DIVISOR_W-1:0] b);
    startOp(a, b);
    waitDone(tag);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstQuot", quotient, 0);
    chk("rstRem", remainder, 0);
    chk("rstFlags", {29'b0, ready, busy, div_by_zero}, 0);
    reset = 1'b0;

    runOp("d200_10", 200, 10);
    runOp("d65025_255", 65025, 255);
    runOp("d65535_255", 65535, 255);   // back-to-back from DONE
    runOp("d1000_7", 1000, 7);
    runOp("d0_37", 0, 37);
    runOp("d67_1", 67, 1);
    runOp("d96_0", 96, 0);
    runOp("d65535_1", 65535, 1);

    // second start mid-run must be ignored
    startOp(5000, 3);
    while (cyc < e0 + 4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 9; divisor = 3;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("ignoreStart");

    // reset aborts an operation in flight
    startOp(1234, 5);
    void'(expQ.pop_back());
    while (cyc < e0 + 7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abortQuot", quotient, 0);
    chk("abortRem", remainder, 0);
    chk("abortFlags", {29'b0, ready, busy, div_by_zero}, 0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("abortStayIdle", {30'b0, ready, busy}, 0);
    runOp("d100_9", 100, 9);

    // reset wins over simultaneous start
    @(negedge clk);
    reset = 1'b1; start = 1'b1; dividend = 50; divisor = 5;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rstStartFlags", {29'b0, ready, busy, div_by_zero}, 0);
    repeat (18) @(posedge clk);
    #1;
    chk("rstStartIdle", {30'b0, ready, busy}, 0);

    for (int i = 0; i < 6; i++)
      runOp("rand", DIVIDEND_W'($urandom), DIVISOR_W'($urandom_range(1, 255)));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential restoring (shift-subtract) unsigned integer divider; the inverse functional unit of the team's sequential multiplier.
- Divides a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor, producing one quotient bit per clock.
- Sits beside the multiplier in the arithmetic function-unit set and uses the same level-style ready completion flag.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width (equals the multiplier result width).
- DIVISOR_W, 8, divisor and remainder width (equals the multiplier operand width).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled on a rising edge.
- dividend  input  DIVIDEND_W  numerator, captured when start is accepted.
- divisor  input  DIVISOR_W  denominator, captured when start is accepted.
- quotient  output  DIVIDEND_W  floor(dividend/divisor); valid while ready=1.
- remainder  output  DIVISOR_W  dividend mod divisor; valid while ready=1.
- ready  output  1  result valid; level signal.
- busy  output  1  division in progress.
- div_by_zero  output  1  the last accepted divisor was 0; valid while ready=1.

Behaviour:
- Clocking and reset: one clock (clk). reset is synchronous and active-high.
- Reset state: at any edge with reset=1, state=IDLE and quotient=0, remainder=0, ready=0, busy=0, div_by_zero=0.
- Reset priority: reset overrides start in the same cycle, and overrides an operation in flight (abort, no partial result is exposed).
- States:
  - IDLE: waiting.
  - RUN: iterating.
  - DONE: result held.
- Start acceptance:
  - start=1 in IDLE or DONE at edge E0: capture dividend and divisor into internal registers; clear quotient, remainder, ready and div_by_zero to 0.
  - Then: if divisor=0, go to DONE; otherwise set busy=1, iteration count=0 and go to RUN.
  - start while in RUN is ignored. No queueing, no restart.
  - Inputs may change after E0 without effect.
- Division by zero: at edge E0+1, quotient=all ones (16'hFFFF), remainder=0, div_by_zero=1, ready=1.
- RUN iteration (one per edge):
  - Working registers: a DIVISOR_W+1-bit partial remainder and a DIVIDEND_W-bit shift register holding the dividend bits, which become the quotient bits.
  - Step 1: shift the partial remainder left, bringing in the current dividend MSB.
  - Step 2: if the partial remainder is >= divisor (unsigned, using the full DIVISOR_W+1 width), subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - The extra partial-remainder bit prevents overflow when the divisor is at or near 2^DIVISOR_W−1.
- Completion:
  - The final (DIVIDEND_W-th) iteration occurs at edge E0+DIVIDEND_W (E0+16 at default width).
  - At that edge: write quotient and remainder, set ready=1, busy=0 and div_by_zero=0, and go to DONE.
  - Latency from start sampled to ready: 16 cycles at default width (1 cycle for divide-by-zero).
- DONE:
  - Outputs are held stable indefinitely.
  - ready stays 1 until the next accepted start or reset.
  - A new start in DONE behaves exactly as from IDLE (back-to-back operation allowed; ready drops at E0).
- Output invariants:
  - busy and ready are never both 1.
  - quotient*divisor + remainder = dividend, and remainder < divisor, whenever ready=1 and div_by_zero=0.

Test Plan:
- Reset, then start with 200 / 10 → ready=1 exactly 16 edges after the start edge; quotient=20, remainder=0, div_by_zero=0; busy=1 during edges 1..15.
- 65025 / 255 → quotient=255, remainder=0. Then a back-to-back start from DONE with 65535 / 255 → ready drops, then quotient=257, remainder=0.
- 1000 / 7 → quotient=142, remainder=6. 0 / 37 → quotient=0, remainder=0. 67 / 1 → quotient=67, remainder=0.
- 96 / 0 → one edge after start: ready=1, div_by_zero=1, quotient=16'hFFFF, remainder=0, busy=0 throughout.
- Start 5000 / 3; pulse start again with 9 / 3 at edge E0+5 → the second start is ignored; result is quotient=1666, remainder=2 at E0+16.
- Start 1234 / 5; assert reset at edge E0+8 → at that edge all outputs are 0 and state is IDLE. Then start 100 / 9 → quotient=11, remainder=1 after 16 edges. reset and start together → start ignored.
